// File: rtl/pc_branch_unit.sv
// Fetch/branch-resolution unit: owns the PC, fetches over req/ack, hands words to decode.
// Optional branch statistics counters are enabled with the PC_BRANCH_STAT_EN macro.
`timescale 1ns/1ps
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        br_req,
  input  logic [31:0] br_offset,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  input  logic        alu_valid,
  input  logic        alu_zero,
  output logic [31:0] pc
`ifdef PC_BRANCH_STAT_EN
  ,
  output logic [15:0] br_taken_cnt,
  output logic [15:0] br_ntaken_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, BR_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;
  logic        br_taken, br_ntaken;

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign imem_err   = err_q;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc         = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    br_taken  = 1'b0;
    br_ntaken = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          to_cnt_d  = '0;
          state_d   = HOLD;
        end else begin
          // Counter saturates so a long stall can never wrap back below the limit.
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 32'd1;
          if (IMEM_TIMEOUT != 0 && (to_cnt_q + 32'd1) >= IMEM_TIMEOUT) err_d = 1'b1;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          if (jmp_req) begin
            pc_d    = jmp_target & 32'hFFFF_FFFC;
            state_d = FETCH;
          end else if (br_req) begin
            tgt_d   = inst_pc_q + 32'd4 + (br_offset << 2);
            pc_d    = inst_pc_q + 32'd4;
            state_d = BR_WAIT;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end
        end
      end
      BR_WAIT: begin
        if (alu_valid) begin
          if (alu_zero) pc_d = tgt_q;
          br_taken  = alu_zero;
          br_ntaken = ~alu_zero;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

`ifdef PC_BRANCH_STAT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] ntaken_cnt_q, ntaken_cnt_d;

  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (br_taken && taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 16'd1;
    if (br_ntaken && ntaken_cnt_q != '1) ntaken_cnt_d = ntaken_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign br_taken_cnt  = taken_cnt_q;
  assign br_ntaken_cnt = ntaken_cnt_q;
`else
  logic stat_unused;
  assign stat_unused = br_taken | br_ntaken;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized self-checking bench for pc_branch_unit against a transaction-level PC model.
`timescale 1ns/1ps
module tb_pc_branch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          TO  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_ack, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        br_req, jmp_req, alu_valid, alu_zero;
  logic [31:0] br_offset, jmp_target, pc;
`ifdef PC_BRANCH_STAT_EN
  logic [15:0] br_taken_cnt, br_ntaken_cnt;
`endif

  pc_branch_unit #(.RESET_PC(RPC), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .br_req(br_req), .br_offset(br_offset), .jmp_req(jmp_req), .jmp_target(jmp_target),
    .alu_valid(alu_valid), .alu_zero(alu_zero), .pc(pc)
`ifdef PC_BRANCH_STAT_EN
    , .br_taken_cnt(br_taken_cnt), .br_ntaken_cnt(br_ntaken_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ea;        // address the next fetch must use
  bit          err_m;
  int          taken_m, ntaken_m;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_pc", pc, RPC);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_err", {31'd0, imem_err}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
  endtask

  task automatic model_reset();
    ea = RPC; err_m = 0; taken_m = 0; ntaken_m = 0;
  endtask

  task automatic wait_req(input int exp_wait);
    int w = 0;
    while (imem_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("fetch_latency", w, exp_wait);
  endtask

  task automatic check_stats();
`ifdef PC_BRANCH_STAT_EN
    check("taken_cnt", {16'd0, br_taken_cnt}, taken_m);
    check("ntaken_cnt", {16'd0, br_ntaken_cnt}, ntaken_m);
`endif
  endtask

  // kind: 0 plain, 1 branch, 2 jump, 3 jump+branch, 4 branch aborted by reset
  task automatic run_instr(input int lat, input int rdy_dly, input int kind,
                           input logic [31:0] arg, input int alu_dly, input bit zero,
                           input int exp_wait);
    logic [31:0] word, tgt;
    word = $urandom;
    wait_req(exp_wait);
    check("imem_addr", imem_addr, ea);
    check("pc", pc, ea);
    for (int k = 1; k <= lat; k++) begin
      imem_ack = 0; imem_rdata = $urandom;
      @(negedge clk);
      if (k >= TO) err_m = 1;
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("imem_err", {31'd0, imem_err}, {31'd0, err_m});
    end
    imem_ack = 1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 0; imem_rdata = $urandom;
    check("inst_valid", {31'd0, inst_valid}, 32'd1);
    check("inst", inst, word);
    check("inst_pc", inst_pc, ea);
    check("req_drop", {31'd0, imem_req}, 32'd0);
    check("err_sticky", {31'd0, imem_err}, {31'd0, err_m});
    for (int k = 0; k < rdy_dly; k++) begin
      inst_ready = 0; br_req = $urandom; jmp_req = $urandom; br_offset = $urandom;
      jmp_target = $urandom; alu_valid = $urandom; alu_zero = $urandom;
      @(negedge clk);
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_inst", inst, word);
    end
    inst_ready = 1;
    br_req = (kind == 1 || kind == 3 || kind == 4);
    jmp_req = (kind == 2 || kind == 3);
    br_offset = arg; jmp_target = arg;
    alu_valid = 1; alu_zero = ~zero;
    @(negedge clk);
    inst_ready = 0; br_req = 0; jmp_req = 0; alu_valid = 0;
    check("hs_valid_drop", {31'd0, inst_valid}, 32'd0);
    if (kind == 2 || kind == 3) begin
      ea = {arg[31:2], 2'b00};
    end else if (kind == 1) begin
      tgt = ea + 32'd4 + arg * 32'd4;
      check("br_no_req", {31'd0, imem_req}, 32'd0);
      for (int k = 0; k < alu_dly; k++) begin
        alu_valid = 0; alu_zero = $urandom;
        @(negedge clk);
        check("br_wait_no_req", {31'd0, imem_req}, 32'd0);
      end
      alu_valid = 1; alu_zero = zero;
      @(negedge clk);
      alu_valid = 0;
      if (zero) begin ea = tgt; taken_m++; end
      else begin ea = ea + 32'd4; ntaken_m++; end
      check_stats();
    end else if (kind == 4) begin
      #2 rst_n = 0;
      #1 check_reset_vals();
      alu_valid = 1; alu_zero = 1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      @(negedge clk);
      alu_valid = 0;
      check("late_alu_pc", pc, RPC);
      check_stats();
    end else begin
      ea = ea + 32'd4;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, lat;
    imem_ack = 0; imem_rdata = '0; inst_ready = 0; br_req = 0; jmp_req = 0;
    br_offset = '0; jmp_target = '0; alu_valid = 0; alu_zero = 0;
    model_reset();
    #3 rst_n = 0;
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1;

    // sequential fetch from the reset PC
    run_instr(0, 0, 0, 32'd0, 0, 0, 1);
    run_instr(0, 0, 0, 32'd0, 0, 0, 0);
    run_instr(0, 0, 0, 32'd0, 0, 0, 0);
    // backward branch at 0x200, taken then not taken
    run_instr(0, 0, 2, 32'h0000_0200, 0, 0, 0);
    run_instr(0, 0, 1, 32'hFFFF_FFFE, 1, 1, 0);
    run_instr(0, 0, 2, 32'h0000_0200, 0, 0, 0);
    run_instr(0, 0, 1, 32'hFFFF_FFFE, 1, 0, 0);
    // jump wins over branch, low bits dropped
    run_instr(0, 1, 3, 32'h0000_3003, 0, 1, 0);
    // wrap at the top of the address space
    run_instr(0, 0, 2, 32'hFFFF_FFFC, 0, 0, 0);
    run_instr(0, 0, 0, 32'd0, 0, 0, 0);
    run_instr(1, 0, 0, 32'd0, 0, 0, 0);
    // fetch stall long enough to trip the timeout
    run_instr(6, 0, 0, 32'd0, 0, 0, 0);
    run_instr(0, 0, 0, 32'd0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      lat  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
      run_instr(lat, $urandom_range(0, 3), kind, $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

    // reset while waiting on the ALU flag
    run_instr(0, 0, 4, 32'h0000_0010, 0, 1, 0);
    run_instr(0, 0, 1, 32'h0000_0003, 0, 1, 0);
    run_instr(0, 0, 1, 32'h0000_0005, 2, 1, 0);
    run_instr(0, 0, 1, 32'hFFFF_FFF0, 0, 0, 0);
    run_instr(1, 2, 1, 32'h0000_0001, 3, 1, 0);
    run_instr(0, 0, 0, 32'd0, 0, 0, 0);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
